// File: rtl/riscv_proc_ctrl_pkg.sv
// Shared constants and helpers for the fetch-control slice of the processor.
package riscv_proc_ctrl_pkg;

    localparam int DEPTH_DEF = 8;
    localparam int WIDTH_DEF = 32;

    // Smallest b with 2**b >= n; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int b;
        b = 0;
        while ((32'sd1 <<< b) < n) begin
            b = b + 1;
        end
        return b;
    endfunction

endpackage

// File: rtl/riscv_proc_ctrl_occ.sv
// Up/down occupancy counter with synchronous load; the increment and decrement
// amounts are small so several events can retire in the same cycle.
module riscv_proc_ctrl_occ
    import riscv_proc_ctrl_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic [1:0]   inc,
    input  logic [1:0]   dec,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_r;

    // Counter register: reset clears, load overrides, otherwise net inc/dec.
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_r <= {W{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else begin
            cnt_r <= cnt_r + W'(inc) - W'(dec);
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/riscv_proc_ctrl_fetch_q.sv
// Credit-based instruction fetch queue: issues imem requests only while a
// buffer slot is guaranteed, buffers responses in order, and drops stale ones after a kill.
module riscv_proc_ctrl_fetch_q
    import riscv_proc_ctrl_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pc_val,
    output logic             pc_rdy,
    output logic             mem_req_val,
    input  logic             mem_req_rdy,
    input  logic             mem_resp_val,
    input  logic [WIDTH-1:0] mem_resp_data,
    input  logic             kill,
    output logic             inst_val,
    output logic [WIDTH-1:0] inst_data,
    input  logic             inst_rdy
);

    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [CW-1:0]    c_cnt_s;
    logic [CW-1:0]    f_cnt_s;
    logic [CW-1:0]    d_cnt_s;
    logic [CW-1:0]    kill_d_s;
    logic             credit_ok_s;
    logic             buf_empty_s;
    logic             issue_s;
    logic             deq_s;
    logic             drop_s;
    logic             wr_s;
    logic [1:0]       c_inc_s;
    logic [1:0]       c_dec_s;
    logic [1:0]       f_inc_s;
    logic [1:0]       f_dec_s;
    logic [1:0]       d_dec_s;
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];

    // Handshakes and counter deltas. Every buffered word is accounted as
    // C - F, so the queue is empty exactly when C equals F.
    always_comb begin
        credit_ok_s = (c_cnt_s < DEPTH_C);
        buf_empty_s = (c_cnt_s == f_cnt_s);
        inst_val    = reset && !buf_empty_s;
        mem_req_val = reset && pc_val && credit_ok_s && !kill;
        pc_rdy      = reset && mem_req_rdy && credit_ok_s && !kill;
        issue_s     = pc_val && pc_rdy;
        deq_s       = inst_val && inst_rdy && !kill;
        drop_s      = mem_resp_val && (d_cnt_s != {CW{1'b0}});
        wr_s        = mem_resp_val && (d_cnt_s == {CW{1'b0}}) && !kill;
        kill_d_s    = f_cnt_s - CW'(mem_resp_val);
        c_inc_s     = {1'b0, issue_s};
        c_dec_s     = {1'b0, drop_s} + {1'b0, deq_s};
        f_inc_s     = {1'b0, issue_s};
        f_dec_s     = {1'b0, mem_resp_val};
        d_dec_s     = {1'b0, drop_s};
    end

    riscv_proc_ctrl_occ #(.W(CW)) u_credit (
        .clk      (clk),
        .reset    (reset),
        .load     (kill),
        .load_val (kill_d_s),
        .inc      (c_inc_s),
        .dec      (c_dec_s),
        .cnt      (c_cnt_s)
    );

    riscv_proc_ctrl_occ #(.W(CW)) u_inflight (
        .clk      (clk),
        .reset    (reset),
        .load     (1'b0),
        .load_val ({CW{1'b0}}),
        .inc      (f_inc_s),
        .dec      (f_dec_s),
        .cnt      (f_cnt_s)
    );

    riscv_proc_ctrl_occ #(.W(CW)) u_drop (
        .clk      (clk),
        .reset    (reset),
        .load     (kill),
        .load_val (kill_d_s),
        .inc      (2'b00),
        .dec      (d_dec_s),
        .cnt      (d_cnt_s)
    );

    // FIFO pointers; a kill empties the buffer by snapping the head to the tail.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
        end else begin
            if (wr_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (kill) begin
                rd_ptr_r <= wr_ptr_r;
            end else if (deq_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
        end
    end

    // Response storage; contents are only meaningful while inst_val is high.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            mem_r[wr_ptr_r] <= mem_resp_data;
        end
    end

    assign inst_data = mem_r[rd_ptr_r];

endmodule

// File: doc/riscv_proc_ctrl_fetch_q.md
RISCV_PROC_CTRL_FETCH_Q -- requirements
Module: riscv_proc_ctrl_fetch_q

Interface
REQ-001 SHALL have parameter DEPTH, default 8: response-buffer entries and maximum outstanding-plus-buffered fetches; power of 2, at least 2.
REQ-002 SHALL have parameter WIDTH, default 32: instruction word width.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous and active-low (asserted when 0).
REQ-005 SHALL have port pc_val  input  1  upstream fetch request valid.
REQ-006 SHALL have port pc_rdy  output  1  fetch request accepted this cycle when pc_val is also 1.
REQ-007 SHALL have port mem_req_val  output  1  imem request valid.
REQ-008 SHALL have port mem_req_rdy  input  1  imem can accept a request.
REQ-009 SHALL have port mem_resp_val  input  1  imem response valid; cannot be back-pressured.
REQ-010 SHALL have port mem_resp_data  input  WIDTH  imem response word.
REQ-011 SHALL have port kill  input  1  redirect: flush buffered words and discard in-flight responses.
REQ-012 SHALL have port inst_val  output  1  buffered instruction available.
REQ-013 SHALL have port inst_data  output  WIDTH  head-of-queue instruction.
REQ-014 SHALL have port inst_rdy  input  1  downstream consumes the head when inst_val is 1.

Function
REQ-015 SHALL keep credit count C (0..DEPTH) = in-flight requests + buffered words + pending drops.
REQ-016 SHALL drive mem_req_val = pc_val && C<DEPTH && !kill, and pc_rdy = mem_req_rdy && C<DEPTH && !kill.
REQ-017 SHALL define issue = pc_val && pc_rdy; issue increments C and the in-flight count F.
REQ-018 SHALL decrement F on every mem_resp_val, in order with issues.
REQ-019 SHALL write mem_resp_data into the FIFO tail when mem_resp_val is 1 and drop count D is 0 and kill is 0; the word is visible on inst_data no earlier than the next cycle, with no bypass.
REQ-020 SHALL discard a response arriving with D>0, decrement D and C.
REQ-021 SHALL drive inst_val = FIFO not empty; deq = inst_val && inst_rdy pops the head and decrements C.
REQ-022 On kill SHALL empty the FIFO, set D to F minus the response arriving that cycle, and set C to that same D value; a same-cycle response is discarded; a same-cycle deq has no additional effect.
REQ-023 SHALL apply simultaneous issue, response and deq as net arithmetic on C and F; C SHALL never exceed DEPTH or underflow.
REQ-024 SHALL use pointers of log2(DEPTH) bits that wrap modulo DEPTH, and counts of log2(DEPTH)+1 bits.
REQ-025 A response SHALL never find the FIFO full; this is guaranteed by the credit rule in REQ-016.

Reset
REQ-026 While reset=0 at a clock edge, SHALL clear C, F, D and both pointers; inst_val=0, mem_req_val=0 and pc_rdy=0 follow combinationally.
REQ-027 Reset asserted mid-operation SHALL abandon in-flight responses; the environment guarantees no mem_resp_val from before reset.
REQ-028 inst_data SHALL be don't-care while inst_val=0; storage needs no reset.

Structure
REQ-029 SHALL place DEPTH/WIDTH defaults and a ceil-log2 constant function in shared package riscv_proc_ctrl_pkg.
REQ-030 SHALL implement C, F and D with one sub-module, riscv_proc_ctrl_occ: an up/down counter with synchronous load, instantiated three times.
REQ-031 SHALL register state only; outputs SHALL be combinational from state and inputs as stated, giving 120-400 lines of RTL total.

Verification
REQ-032 Fill: pc_val=1, mem_req_rdy=1, no responses, 9 cycles -> exactly 8 issues; pc_rdy=0 from cycle 9.
REQ-033 Latency: one issue, response 0xDEADBEEF at cycle t -> inst_val=1 with inst_data=0xDEADBEEF at t+1, not at t.
REQ-034 Kill with 3 in flight and 2 buffered -> inst_val=0 next cycle; next 3 responses discarded; C=0 after the third; new issues proceed.
REQ-035 Kill coincident with a response, F=2 -> that response and one more discarded; the following response is buffered.
REQ-036 Simultaneous issue, response and deq at C=DEPTH-1 -> C stays DEPTH-1; FIFO order preserved across pointer wrap over 20 transfers.
REQ-037 Reset=0 for one cycle mid-stream -> C=F=D=0, inst_val=0, and pc_rdy follows mem_req_rdy on the next cycle.
